// File: rtl/reg_bank_pkg.sv
// Shared constants for the forwarding register bank: operand-source encodings
// and the hardwired-zero register index.
package reg_bank_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_EX = 2'b01;
  localparam logic [1:0] FWD_DM = 2'b10;
  localparam logic [1:0] FWD_WB = 2'b11;

  localparam int REG_ZERO = 0;

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: one pending-write flag per register, updated on each edge.
// When a register is set and cleared in the same cycle, the set wins (new producer).
module reg_scoreboard
  import reg_bank_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                set_en_i,
  input  logic [ADDR_W-1:0]   set_addr_i,
  input  logic                clr_en_i,
  input  logic [ADDR_W-1:0]   clr_addr_i,
  output logic [NUM_REGS-1:0] busy_o
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_en_i && (clr_addr_i != ZERO_ADDR)) busy_d[clr_addr_i] = 1'b0;
    if (set_en_i && (set_addr_i != ZERO_ADDR)) busy_d[set_addr_i] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/register_bank_fwd.sv
// ID-stage register file with per-port EX/DM/WB forwarding, write-first bypass and
// busy-bit stall; operands registered (1-cycle latency), held while stall is high.
module register_bank_fwd
  import reg_bank_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic [NUM_RD*2-1:0]      fwd_sel,
  input  logic [DATA_W-1:0]        ans_ex,
  input  logic [DATA_W-1:0]        mux_ans_dm,
  input  logic [DATA_W-1:0]        ans_wb,
  input  logic [DATA_W-1:0]        imm,
  input  logic                     imm_sel,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     issue_valid,
  input  logic                     issue_wen,
  input  logic [ADDR_W-1:0]        issue_dst,
  output logic                     stall,
  output logic [NUM_RD*DATA_W-1:0] rd_data
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0]        regs_q [NUM_REGS];
  logic [NUM_RD*DATA_W-1:0] rd_data_q;
  logic [NUM_RD*DATA_W-1:0] rd_data_d;
  logic [NUM_REGS-1:0]      busy;
  logic [NUM_RD-1:0]        hazard;
  logic                     sb_set;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_en && (wr_addr != ZERO_ADDR)) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_port
    localparam logic LAST = (k == NUM_RD - 1);
    logic [ADDR_W-1:0] addr;
    logic [1:0]        sel;
    logic              wr_hit;
    logic              use_imm;
    logic [DATA_W-1:0] rf_val;
    logic [DATA_W-1:0] fwd_val;

    assign addr    = rd_addr[k*ADDR_W +: ADDR_W];
    assign sel     = fwd_sel[k*2 +: 2];
    assign wr_hit  = wr_en && (wr_addr == addr);
    assign use_imm = LAST && imm_sel;
    assign rf_val  = (wr_hit && (wr_addr != ZERO_ADDR)) ? wr_data : regs_q[addr];

    always_comb begin
      case (sel)
        FWD_EX:  fwd_val = ans_ex;
        FWD_DM:  fwd_val = mux_ans_dm;
        FWD_WB:  fwd_val = ans_wb;
        default: fwd_val = rf_val;
      endcase
    end

    assign rd_data_d[k*DATA_W +: DATA_W] = use_imm ? imm : fwd_val;
    // A same-cycle write to the source resolves the hazard through the bypass.
    assign hazard[k] = busy[addr] && (sel == FWD_RF) && !use_imm && !wr_hit;
  end

  assign stall  = reset && issue_valid && (|hazard);
  assign sb_set = issue_valid && issue_wen && !stall;

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .set_en_i   (sb_set),
    .set_addr_i (issue_dst),
    .clr_en_i   (wr_en),
    .clr_addr_i (wr_addr),
    .busy_o     (busy)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      rd_data_q <= '0;
    else if (!stall) rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_register_bank_fwd.sv
// Directed bench for register_bank_fwd: table of per-cycle vectors plus a
// hand-written mid-operation reset sequence.
module tb_register_bank_fwd;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  rd_addr;
  logic [3:0]  fwd_sel;
  logic [7:0]  ans_ex, mux_ans_dm, ans_wb, imm, wr_data;
  logic        imm_sel, wr_en, issue_valid, issue_wen;
  logic [4:0]  wr_addr, issue_dst;
  logic        stall;
  logic [15:0] rd_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  register_bank_fwd dut (
    .clk         (clk),
    .reset       (reset),
    .rd_addr     (rd_addr),
    .fwd_sel     (fwd_sel),
    .ans_ex      (ans_ex),
    .mux_ans_dm  (mux_ans_dm),
    .ans_wb      (ans_wb),
    .imm         (imm),
    .imm_sel     (imm_sel),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .issue_valid (issue_valid),
    .issue_wen   (issue_wen),
    .issue_dst   (issue_dst),
    .stall       (stall),
    .rd_data     (rd_data)
  );

  typedef struct {
    string      name;
    logic [4:0] ra0, ra1;
    logic [1:0] f0, f1;
    logic [7:0] ex, dm, wb, im;
    logic       ims, we;
    logic [4:0] wa;
    logic [7:0] wd;
    logic       iv, iw;
    logic [4:0] id;
    logic       e_stall;
    logic [7:0] e0, e1;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(string n, logic [4:0] ra0, logic [4:0] ra1,
                              logic [1:0] f0, logic [1:0] f1,
                              logic [7:0] ex, logic [7:0] dm, logic [7:0] wb,
                              logic [7:0] im, logic ims, logic we, logic [4:0] wa,
                              logic [7:0] wd, logic iv, logic iw, logic [4:0] id,
                              logic es, logic [7:0] e0, logic [7:0] e1);
    vec_t v;
    v.name = n; v.ra0 = ra0; v.ra1 = ra1; v.f0 = f0; v.f1 = f1;
    v.ex = ex; v.dm = dm; v.wb = wb; v.im = im; v.ims = ims;
    v.we = we; v.wa = wa; v.wd = wd; v.iv = iv; v.iw = iw; v.id = id;
    v.e_stall = es; v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    rd_addr = '0; fwd_sel = '0; ans_ex = '0; mux_ans_dm = '0; ans_wb = '0;
    imm = '0; imm_sel = 0; wr_en = 0; wr_addr = '0; wr_data = '0;
    issue_valid = 0; issue_wen = 0; issue_dst = '0;
  endtask

  task automatic apply(vec_t v);
    rd_addr = {v.ra1, v.ra0}; fwd_sel = {v.f1, v.f0};
    ans_ex = v.ex; mux_ans_dm = v.dm; ans_wb = v.wb; imm = v.im; imm_sel = v.ims;
    wr_en = v.we; wr_addr = v.wa; wr_data = v.wd;
    issue_valid = v.iv; issue_wen = v.iw; issue_dst = v.id;
  endtask

  initial begin
    // name, ra0, ra1, f0, f1, ex, dm, wb, imm, imm_sel, we, wa, wd, iv, iw, id, stall, rd0, rd1
    vecs[0]  = mk("rd_r5_r6",      5, 6, 0, 0, 0,    0,    0,    0,    0, 0, 0, 0,    1, 0, 0, 0, 8'h00, 8'h00);
    vecs[1]  = mk("wr_r5",         0, 0, 0, 0, 0,    0,    0,    0,    0, 1, 5, 8'h2A, 0, 0, 0, 0, 8'h00, 8'h00);
    vecs[2]  = mk("rd_r5_byp_r6",  5, 6, 0, 0, 0,    0,    0,    0,    0, 1, 6, 8'h11, 1, 0, 0, 0, 8'h2A, 8'h11);
    vecs[3]  = mk("fwd_ex_dm",     5, 6, 1, 2, 8'h01, 8'h05, 0,  0,    0, 0, 0, 0,    1, 0, 0, 0, 8'h01, 8'h05);
    vecs[4]  = mk("imm_port1",     5, 6, 1, 2, 8'h01, 8'h05, 0,  8'h04, 1, 0, 0, 0,   1, 0, 0, 0, 8'h01, 8'h04);
    vecs[5]  = mk("fwd_wb",        6, 5, 3, 0, 0,    0,    8'h77, 0,   0, 0, 0, 0,    1, 0, 0, 0, 8'h77, 8'h2A);
    vecs[6]  = mk("issue_r7",      5, 6, 0, 0, 0,    0,    0,    0,    0, 0, 0, 0,    1, 1, 7, 0, 8'h2A, 8'h11);
    vecs[7]  = mk("r7_stall_p0",   7, 5, 0, 0, 0,    0,    0,    0,    0, 0, 0, 0,    1, 0, 0, 1, 8'h2A, 8'h11);
    vecs[8]  = mk("r7_fwd_ex",     7, 5, 1, 0, 8'h99, 0,   0,    0,    0, 0, 0, 0,    1, 0, 0, 0, 8'h99, 8'h2A);
    vecs[9]  = mk("r7_imm_exempt", 5, 7, 0, 0, 0,    0,    0,    8'h42, 1, 0, 0, 0,   1, 0, 0, 0, 8'h2A, 8'h42);
    vecs[10] = mk("r7_stall_p1",   5, 7, 0, 0, 0,    0,    0,    0,    0, 0, 0, 0,    1, 0, 0, 1, 8'h2A, 8'h42);
    vecs[11] = mk("bubble",        5, 7, 0, 0, 0,    0,    0,    0,    0, 0, 0, 0,    0, 0, 0, 0, 8'h2A, 8'h00);
    vecs[12] = mk("wr_r7_release", 7, 5, 0, 0, 0,    0,    0,    0,    0, 1, 7, 8'h33, 1, 0, 0, 0, 8'h33, 8'h2A);
    vecs[13] = mk("r7_free",       7, 7, 0, 0, 0,    0,    0,    0,    0, 0, 0, 0,    1, 0, 0, 0, 8'h33, 8'h33);
    vecs[14] = mk("issue_wr_r3",   3, 0, 0, 0, 0,    0,    0,    0,    0, 1, 3, 8'h55, 1, 1, 3, 0, 8'h55, 8'h00);
    vecs[15] = mk("r3_set_wins",   3, 0, 0, 0, 0,    0,    0,    0,    0, 0, 0, 0,    1, 0, 0, 1, 8'h55, 8'h00);
    vecs[16] = mk("r3_clear",      3, 0, 0, 0, 0,    0,    0,    0,    0, 1, 3, 8'h56, 0, 0, 0, 0, 8'h56, 8'h00);
    vecs[17] = mk("wr_r0",         0, 0, 0, 0, 0,    0,    0,    0,    0, 1, 0, 8'hFF, 1, 1, 0, 0, 8'h00, 8'h00);
    vecs[18] = mk("rd_r0",         0, 3, 0, 0, 0,    0,    0,    0,    0, 0, 0, 0,    1, 0, 0, 0, 8'h00, 8'h56);

    clear_inputs();
    reset = 1'b0;
    #100;
    rd_addr = {5'd6, 5'd5}; issue_valid = 1;
    #1;
    chk("reset_stall", 16'(stall), 16'h0);
    chk("reset_rd_data", rd_data, 16'h0000);
    #99;
    reset = 1'b1;

    @(posedge clk); #1;
    foreach (vecs[i]) begin
      apply(vecs[i]);
      #1;
      chk({vecs[i].name, "_stall"}, 16'(stall), 16'(vecs[i].e_stall));
      @(posedge clk); #1;
      chk({vecs[i].name, "_rd"}, rd_data, {vecs[i].e1, vecs[i].e0});
    end

    // Reset asserted while r7 is busy and a reader is stalled.
    clear_inputs();
    rd_addr = {5'd6, 5'd5}; issue_valid = 1; issue_wen = 1; issue_dst = 5'd7;
    @(posedge clk); #1;
    chk("pre_rst_rd", rd_data, 16'h112A);
    issue_wen = 0; rd_addr = {5'd0, 5'd7};
    #1;
    chk("pre_rst_stall", 16'(stall), 16'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_stall", 16'(stall), 16'h0);
    chk("mid_rst_rd", rd_data, 16'h0000);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("post_rst_busy_clr", 16'(stall), 16'h0);
    @(posedge clk); #1;
    chk("post_rst_r7", rd_data, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/register_bank_fwd.md
Name: register_bank_fwd

Overview:
Parametrised successor to the 8-bit register bank. It provides a register file with configurable width, depth and read-port count. Each read port has per-operand forwarding from the EX, DM and WB stages, and the last port has an immediate override. It adds a write-first internal bypass and a busy-bit scoreboard that raises a stall when a source register is still pending and no forwarding path is selected. It sits in the ID stage, between instruction decode and the EX operand latches.

Parameters:
DATA_W, 8, register and operand width in bits
NUM_REGS, 32, number of architectural registers (power of 2, >=4)
ADDR_W, $clog2(NUM_REGS), register address width
NUM_RD, 2, number of read ports (2..4); port NUM_RD-1 carries the immediate mux

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
rd_addr  in  NUM_RD*ADDR_W  packed source register addresses, port k at [k*ADDR_W +: ADDR_W]
fwd_sel  in  NUM_RD*2  packed per-port operand source select
ans_ex  in  DATA_W  forwarded EX result
mux_ans_dm  in  DATA_W  forwarded DM result
ans_wb  in  DATA_W  forwarded WB result
imm  in  DATA_W  immediate operand
imm_sel  in  1  1 = port NUM_RD-1 outputs imm
wr_en  in  1  register write enable (from WB)
wr_addr  in  ADDR_W  write destination (RW_dm role)
wr_data  in  DATA_W  write data
issue_valid  in  1  an instruction is presented for issue this cycle
issue_wen  in  1  the issuing instruction writes a register
issue_dst  in  ADDR_W  destination of the issuing instruction
stall  out  1  combinational; 1 = hold the issuing instruction
rd_data  out  NUM_RD*DATA_W  registered operands, packed like rd_addr

Behaviour:
- Reset (reset=0, asynchronous): all registers = 0, rd_data = 0, all busy bits = 0. stall reads 0 while reset is asserted.
- Register 0 is hardwired to zero:
  - writes to it are ignored;
  - it is never marked busy;
  - reads of it return 0 when fwd_sel=FWD_RF.
- Write: on a clk rising edge with wr_en=1 and wr_addr!=0, reg[wr_addr] <= wr_data.
- Read path, per port k, computed combinationally:
  - rf_k = (wr_en && wr_addr==rd_addr_k && wr_addr!=0) ? wr_data : reg[rd_addr_k] (write-first bypass).
  - fwd_sel encoding: 00 selects rf_k, 01 ans_ex, 10 mux_ans_dm, 11 ans_wb.
  - Port NUM_RD-1 only: if imm_sel=1, the operand is imm, regardless of fwd_sel.
- Output timing: rd_data is registered and updates on the clk edge following valid inputs, i.e. 1-cycle latency. When stall=1, rd_data holds its previous value.
- Scoreboard: one busy bit per register.
  - Set: on a clk edge with issue_valid && issue_wen && !stall && issue_dst!=0, busy[issue_dst] <= 1.
  - Clear: on a clk edge with wr_en && wr_addr!=0, busy[wr_addr] <= 0.
  - Same register set and cleared in the same cycle: set wins, because the new producer supersedes the retiring one.
- Stall condition: stall = issue_valid && (any port k with busy[rd_addr_k]=1 && fwd_sel_k=FWD_RF && !(k==NUM_RD-1 && imm_sel) && !(wr_en && wr_addr==rd_addr_k)). A write to the same register in the stall cycle releases the stall, via the bypass.
- When issue_valid=0, stall=0 and rd_data still updates; this is a bubble.
- All arithmetic is unsigned equality compare only. There is no width extension: every data path is exactly DATA_W.
- Reset asserted mid-operation clears the scoreboard immediately, and any pending stall drops.

Decomposition:
- Package reg_bank_pkg holds:
  - FWD_RF=2'b00, FWD_EX=2'b01, FWD_DM=2'b10, FWD_WB=2'b11;
  - the zero-register constant REG_ZERO=0.
- Sub-module reg_scoreboard (parameters NUM_REGS and ADDR_W) owns the busy bits and the set/clear/priority rules. It exports busy as a NUM_REGS-bit vector. Stall combination stays in the top level.

Test Plan:
- Reset low for 200 ns, then high; read r5,r6 with fwd_sel=00 -> rd_data=0,0 and stall=0.
- Write r5=0x2A, then next cycle read r5 via port 0 -> 0x2A. Same-cycle write r6=0x11 while reading r6 -> 0x11 next edge (bypass).
- Ports 0/1 with fwd_sel=01/10 and ans_ex=0x01, mux_ans_dm=0x05 -> 0x01/0x05. Then imm_sel=1, imm=0x04 -> port 1=0x04, port 0 unchanged.
- Issue dst=r7 (issue_wen=1). Next instruction reads r7 with fwd_sel=00 -> stall=1 and rd_data held. Then wr_en r7=0x33 -> stall=0 that cycle and rd_data=0x33 next edge.
- Same cycle: issue dst=r3 and wr_en r3 -> busy[r3]=1 afterwards. Write to r0=0xFF -> r0 still reads 0 and is never busy.
- Assert reset while busy[r7]=1 and stall=1 -> stall=0 immediately, rd_data=0, and busy is cleared after release.
